memwb: RTL and testbench

Memory/writeback stage of the SWT16 pipeline, directly downstream of the execute stage. It samples the execute stage's result lane, load/store actions and DMEM addresses, and performs each DMEM access over a request/acknowledge handshake with a bounded wait. It stalls the upstream pipeline while an access is outstanding. Completed operations retire as a one-cycle register-file write pulse; a retire counter tracks them.

---
 rtl/memwb.sv | 219 +++++++++++++++++++++
 tb/tb_memwb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memwb.sv
`default_nettype none
// ============================================================================
//  Module   : memwb
//  Purpose  : Memory/writeback stage of the SWT16 pipeline. Samples the
//             execute-stage result lane and load/store actions, runs each DMEM
//             access over a req/ack handshake with a bounded wait, stalls the
//             upstream pipeline while an access is outstanding, and retires
//             completed operations as a one-cycle register-file write pulse.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock / reset             rising-edge clock, asynchronous active-low reset
//    in_act_*                  load / store / write-result flags of the op
//    in_dmem_rd_addr/wr_addr   load / store byte addresses
//    in_dmem_wr_word           store data
//    in_instr, in_res          instruction word and execute result
//    in_res_reg_idx            destination register
//    in_dmem_ack/rdata         DMEM completion and load data
//    out_dmem_req/we/addr/wdata registered DMEM request
//    out_stall                 upstream must hold (access outstanding)
//    out_reg_wr_en/idx/data    register-file write pulse
//    out_instr                 instruction of last retired op
//    out_retire, out_bus_err   completion / timeout pulses
//    out_retire_cnt            wrapping completed-op counter
// ============================================================================
module memwb #(
  parameter int DMEM_ADDR_WIDTH  = 12,
  parameter int DMEM_WORD_WIDTH  = 16,
  parameter int IALU_WORD_WIDTH  = 16,
  parameter int PMEM_WORD_WIDTH  = 16,
  parameter int REG_IDX_WIDTH    = 4,
  parameter int DMEM_TIMEOUT     = 8,
  parameter int RETIRE_CNT_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_act_load_dmem,
  input  logic                        in_act_store_dmem,
  input  logic                        in_act_write_res_to_reg,
  input  logic [DMEM_ADDR_WIDTH-1:0]  in_dmem_rd_addr,
  input  logic [DMEM_ADDR_WIDTH-1:0]  in_dmem_wr_addr,
  input  logic [DMEM_WORD_WIDTH-1:0]  in_dmem_wr_word,
  input  logic [PMEM_WORD_WIDTH-1:0]  in_instr,
  input  logic [IALU_WORD_WIDTH-1:0]  in_res,
  input  logic [REG_IDX_WIDTH-1:0]    in_res_reg_idx,
  input  logic                        in_dmem_ack,
  input  logic [DMEM_WORD_WIDTH-1:0]  in_dmem_rdata,
  output logic                        out_dmem_req,
  output logic                        out_dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0]  out_dmem_addr,
  output logic [DMEM_WORD_WIDTH-1:0]  out_dmem_wdata,
  output logic                        out_stall,
  output logic                        out_reg_wr_en,
  output logic [REG_IDX_WIDTH-1:0]    out_reg_wr_idx,
  output logic [IALU_WORD_WIDTH-1:0]  out_reg_wr_data,
  output logic [PMEM_WORD_WIDTH-1:0]  out_instr,
  output logic                        out_retire,
  output logic                        out_bus_err,
  output logic [RETIRE_CNT_WIDTH-1:0] out_retire_cnt
);

  // Wait counter sized for the largest allowed timeout (255).
  localparam int                 WAIT_W    = 8;
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(DMEM_TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [WAIT_W-1:0]           wait_cnt_q, wait_cnt_d;
  logic                        dmem_req_q, dmem_req_d;
  logic                        dmem_we_q, dmem_we_d;
  logic [DMEM_ADDR_WIDTH-1:0]  dmem_addr_q, dmem_addr_d;
  logic [DMEM_WORD_WIDTH-1:0]  dmem_wdata_q, dmem_wdata_d;
  logic                        reg_wr_en_q, reg_wr_en_d;
  logic [REG_IDX_WIDTH-1:0]    reg_wr_idx_q, reg_wr_idx_d;
  logic [IALU_WORD_WIDTH-1:0]  reg_wr_data_q, reg_wr_data_d;
  logic [PMEM_WORD_WIDTH-1:0]  instr_q, instr_d;
  logic                        retire_q, retire_d;
  logic                        bus_err_q, bus_err_d;
  logic [RETIRE_CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;
  // Context of the outstanding access, applied when it completes.
  logic                        pend_wres_q, pend_wres_d;
  logic [REG_IDX_WIDTH-1:0]    pend_idx_q, pend_idx_d;
  logic [PMEM_WORD_WIDTH-1:0]  pend_instr_q, pend_instr_d;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    dmem_req_d    = dmem_req_q;
    dmem_we_d     = dmem_we_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_wdata_d  = dmem_wdata_q;
    reg_wr_en_d   = 1'b0;
    reg_wr_idx_d  = reg_wr_idx_q;
    reg_wr_data_d = reg_wr_data_q;
    instr_d       = instr_q;
    retire_d      = 1'b0;
    bus_err_d     = 1'b0;
    retire_cnt_d  = retire_cnt_q;
    pend_wres_d   = pend_wres_q;
    pend_idx_d    = pend_idx_q;
    pend_instr_d  = pend_instr_q;

    case (state_q)
      ST_IDLE: begin
        if (in_act_store_dmem || in_act_load_dmem) begin
          state_d      = ST_REQ;
          wait_cnt_d   = '0;
          dmem_req_d   = 1'b1;
          pend_idx_d   = in_res_reg_idx;
          pend_instr_d = in_instr;
          if (in_act_store_dmem) begin
            // Store takes priority over a simultaneous load and never
            // writes a register.
            dmem_we_d    = 1'b1;
            dmem_addr_d  = in_dmem_wr_addr;
            dmem_wdata_d = in_dmem_wr_word;
            pend_wres_d  = 1'b0;
          end else begin
            dmem_we_d    = 1'b0;
            dmem_addr_d  = in_dmem_rd_addr;
            dmem_wdata_d = '0;
            pend_wres_d  = in_act_write_res_to_reg;
          end
        end else if (in_act_write_res_to_reg) begin
          reg_wr_en_d   = 1'b1;
          reg_wr_idx_d  = in_res_reg_idx;
          reg_wr_data_d = in_res;
          instr_d       = in_instr;
          retire_d      = 1'b1;
          retire_cnt_d  = retire_cnt_q + RETIRE_CNT_WIDTH'(1);
        end
      end

      ST_REQ: begin
        if (in_dmem_ack) begin
          // Ack beats a coincident timeout.
          state_d      = ST_IDLE;
          dmem_req_d   = 1'b0;
          instr_d      = pend_instr_q;
          retire_d     = 1'b1;
          retire_cnt_d = retire_cnt_q + RETIRE_CNT_WIDTH'(1);
          if (pend_wres_q) begin
            reg_wr_en_d   = 1'b1;
            reg_wr_idx_d  = pend_idx_q;
            reg_wr_data_d = in_dmem_rdata;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_IDLE;
          dmem_req_d = 1'b0;
          bus_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      default: begin
        state_d    = ST_IDLE;
        dmem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_idx_q  <= '0;
      reg_wr_data_q <= '0;
      instr_q       <= '0;
      retire_q      <= 1'b0;
      bus_err_q     <= 1'b0;
      retire_cnt_q  <= '0;
      pend_wres_q   <= 1'b0;
      pend_idx_q    <= '0;
      pend_instr_q  <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_wdata_q  <= dmem_wdata_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_idx_q  <= reg_wr_idx_d;
      reg_wr_data_q <= reg_wr_data_d;
      instr_q       <= instr_d;
      retire_q      <= retire_d;
      bus_err_q     <= bus_err_d;
      retire_cnt_q  <= retire_cnt_d;
      pend_wres_q   <= pend_wres_d;
      pend_idx_q    <= pend_idx_d;
      pend_instr_q  <= pend_instr_d;
    end
  end

  assign out_dmem_req    = dmem_req_q;
  assign out_dmem_we     = dmem_we_q;
  assign out_dmem_addr   = dmem_addr_q;
  assign out_dmem_wdata  = dmem_wdata_q;
  assign out_stall       = (state_q == ST_REQ);
  assign out_reg_wr_en   = reg_wr_en_q;
  assign out_reg_wr_idx  = reg_wr_idx_q;
  assign out_reg_wr_data = reg_wr_data_q;
  assign out_instr       = instr_q;
  assign out_retire      = retire_q;
  assign out_bus_err     = bus_err_q;
  assign out_retire_cnt  = retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_memwb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memwb
//  Purpose  : Self-checking bench for memwb. Directed test-plan steps plus a
//             randomized op stream, each compared against a transaction-level
//             reference model (expected req window length, retire/write/error
//             outcome, running retire count).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_memwb;

  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_act_load_dmem = 1'b0;
  logic        in_act_store_dmem = 1'b0;
  logic        in_act_write_res_to_reg = 1'b0;
  logic [11:0] in_dmem_rd_addr = '0;
  logic [11:0] in_dmem_wr_addr = '0;
  logic [15:0] in_dmem_wr_word = '0;
  logic [15:0] in_instr = '0;
  logic [15:0] in_res = '0;
  logic [3:0]  in_res_reg_idx = '0;
  logic        in_dmem_ack = 1'b0;
  logic [15:0] in_dmem_rdata = '0;
  logic        out_dmem_req, out_dmem_we, out_stall, out_reg_wr_en;
  logic        out_retire, out_bus_err;
  logic [11:0] out_dmem_addr;
  logic [15:0] out_dmem_wdata, out_reg_wr_data, out_instr, out_retire_cnt;
  logic [3:0]  out_reg_wr_idx;

  memwb #(.DMEM_TIMEOUT(T)) dut (
    .clock(clock), .reset(reset),
    .in_act_load_dmem(in_act_load_dmem),
    .in_act_store_dmem(in_act_store_dmem),
    .in_act_write_res_to_reg(in_act_write_res_to_reg),
    .in_dmem_rd_addr(in_dmem_rd_addr), .in_dmem_wr_addr(in_dmem_wr_addr),
    .in_dmem_wr_word(in_dmem_wr_word), .in_instr(in_instr), .in_res(in_res),
    .in_res_reg_idx(in_res_reg_idx), .in_dmem_ack(in_dmem_ack),
    .in_dmem_rdata(in_dmem_rdata),
    .out_dmem_req(out_dmem_req), .out_dmem_we(out_dmem_we),
    .out_dmem_addr(out_dmem_addr), .out_dmem_wdata(out_dmem_wdata),
    .out_stall(out_stall), .out_reg_wr_en(out_reg_wr_en),
    .out_reg_wr_idx(out_reg_wr_idx), .out_reg_wr_data(out_reg_wr_data),
    .out_instr(out_instr), .out_retire(out_retire), .out_bus_err(out_bus_err),
    .out_retire_cnt(out_retire_cnt)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: architectural results of retired ops.
  logic [15:0] m_cnt   = '0;
  logic [3:0]  m_idx   = '0;
  logic [15:0] m_data  = '0;
  logic [15:0] m_instr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_bubble();
    in_act_load_dmem        = 1'b0;
    in_act_store_dmem       = 1'b0;
    in_act_write_res_to_reg = 1'b0;
    in_dmem_ack             = 1'($urandom);   // ack in IDLE must be ignored
    in_dmem_rdata           = 16'($urandom);
    in_res                  = 16'($urandom);
    in_res_reg_idx          = 4'($urandom);
  endtask

  // Random op on the upstream lane while stalled; must not be sampled.
  task automatic set_garbage();
    in_act_load_dmem        = 1'($urandom);
    in_act_store_dmem       = 1'($urandom);
    in_act_write_res_to_reg = 1'($urandom);
    in_dmem_rd_addr         = 12'($urandom);
    in_dmem_wr_addr         = 12'($urandom);
    in_dmem_wr_word         = 16'($urandom);
    in_instr                = 16'($urandom);
    in_res                  = 16'($urandom);
    in_res_reg_idx          = 4'($urandom);
  endtask

  task automatic chk_arch(input string tag);
    chk({tag, "_cnt"},   out_retire_cnt, m_cnt);
    chk({tag, "_idx"},   out_reg_wr_idx, m_idx);
    chk({tag, "_data"},  out_reg_wr_data, m_data);
    chk({tag, "_instr"}, out_instr, m_instr);
  endtask

  // Presents one op at a negedge with stall low and follows it to completion.
  // ack_at: REQ edge (1..T) at which DMEM acks; anything else never acks.
  // hold_next: keep the upstream lane as-is during the stall (back-pressure).
  task automatic run_op(input bit ld, input bit st, input bit wr,
                        input logic [11:0] ra, input logic [11:0] wa,
                        input logic [15:0] wd, input logic [15:0] ins,
                        input logic [15:0] res, input logic [3:0] idx,
                        input int ack_at, input logic [15:0] rdata,
                        input bit hold_next, input string tag);
    bit   acked;
    int   n;
    logic [11:0] e_addr;
    logic [15:0] e_wd;
    in_act_load_dmem        = ld;
    in_act_store_dmem       = st;
    in_act_write_res_to_reg = wr;
    in_dmem_rd_addr = ra;  in_dmem_wr_addr = wa;  in_dmem_wr_word = wd;
    in_instr = ins;  in_res = res;  in_res_reg_idx = idx;
    in_dmem_ack = 1'($urandom);
    @(posedge clock);
    @(negedge clock);
    if (!(ld || st)) begin
      if (wr) begin
        m_cnt++;  m_idx = idx;  m_data = res;  m_instr = ins;
      end
      chk({tag, "_wren"},   out_reg_wr_en, wr);
      chk({tag, "_retire"}, out_retire, wr);
      chk({tag, "_req"},    out_dmem_req, 0);
      chk({tag, "_stall"},  out_stall, 0);
      chk_arch(tag);
      if (!hold_next) set_bubble();
      return;
    end
    acked  = (ack_at >= 1) && (ack_at <= T);
    n      = acked ? ack_at : T;
    e_addr = st ? wa : ra;
    e_wd   = st ? wd : 16'h0;
    for (int i = 1; i <= n; i++) begin
      chk({tag, "_req"},   out_dmem_req, 1);
      chk({tag, "_stall"}, out_stall, 1);
      chk({tag, "_we"},    out_dmem_we, st);
      chk({tag, "_addr"},  out_dmem_addr, e_addr);
      chk({tag, "_wdata"}, out_dmem_wdata, e_wd);
      chk({tag, "_pulse"}, {out_reg_wr_en, out_retire, out_bus_err}, 0);
      if (!hold_next) set_garbage();
      in_dmem_ack   = acked && (i == n);
      in_dmem_rdata = rdata;
      @(posedge clock);
      @(negedge clock);
    end
    in_dmem_ack = 1'b0;
    if (acked) begin
      m_cnt++;  m_instr = ins;
      if (ld && !st && wr) begin
        m_idx = idx;  m_data = rdata;
      end
    end
    chk({tag, "_req_end"},   out_dmem_req, 0);
    chk({tag, "_stall_end"}, out_stall, 0);
    chk({tag, "_wren"},      out_reg_wr_en, acked && ld && !st && wr);
    chk({tag, "_retire"},    out_retire, acked);
    chk({tag, "_buserr"},    out_bus_err, !acked);
    chk_arch(tag);
    if (!hold_next) set_bubble();
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clock);
    chk("rst_req",   out_dmem_req, 0);
    chk("rst_stall", out_stall, 0);
    chk("rst_pulse", {out_reg_wr_en, out_retire, out_bus_err}, 0);
    chk("rst_addr",  {out_dmem_we, out_dmem_addr, out_dmem_wdata}, 0);
    chk_arch("rst");
    reset = 1'b1;
    set_bubble();
    @(negedge clock);

    // Directed test-plan steps.
    run_op(0, 0, 1, 12'h0, 12'h0, 16'h0, 16'hA001, 16'h1234, 4'd3, 0, 16'h0, 0, "alu");
    run_op(1, 0, 1, 12'h040, 12'h0, 16'h0, 16'hA002, 16'h0, 4'd5, 2, 16'hBEEF, 0, "load");
    run_op(0, 1, 0, 12'h0, 12'h100, 16'h00A5, 16'hA003, 16'h0, 4'd6, 1, 16'h0, 0, "store");
    run_op(0, 1, 1, 12'h0, 12'h104, 16'h5A5A, 16'hA004, 16'h7, 4'd7, 1, 16'h1111, 0, "st_wres");
    run_op(1, 1, 1, 12'h0AA, 12'h0BB, 16'hC0DE, 16'hA005, 16'h0, 4'd8, 3, 16'h2222, 0, "ld_st");
    run_op(1, 0, 1, 12'h080, 12'h0, 16'h0, 16'hA006, 16'h0, 4'd9, 0, 16'h3333, 0, "timeout");
    run_op(1, 0, 1, 12'h084, 12'h0, 16'h0, 16'hA007, 16'h0, 4'd10, T, 16'h4444, 0, "ack_last");
    run_op(0, 0, 0, 12'h0, 12'h0, 16'h0, 16'hA008, 16'h0, 4'd11, 0, 16'h0, 0, "bubble");

    // Back-pressure: ALU op held upstream through the load's stall.
    run_op(1, 0, 1, 12'h0C0, 12'h0, 16'h0, 16'hB001, 16'h0, 4'd2, 3, 16'h5555, 1, "bp_load");
    in_act_load_dmem = 1'b0;  in_act_store_dmem = 1'b0;  in_act_write_res_to_reg = 1'b1;
    run_op(0, 0, 1, 12'h0, 12'h0, 16'h0, 16'hB002, 16'h6666, 4'd4, 0, 16'h0, 0, "bp_alu");

    // Randomized op stream.
    for (int k = 0; k < 60; k++) begin
      run_op(1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom), 12'($urandom),
             16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
             int'($urandom_range(0, T + 1)), 16'($urandom), 0, "rand");
    end

    // Asynchronous reset in the middle of an access.
    in_act_load_dmem = 1'b1;  in_act_write_res_to_reg = 1'b1;
    in_dmem_rd_addr = 12'h3C0;  in_res_reg_idx = 4'd12;  in_dmem_ack = 1'b0;
    @(posedge clock);
    @(negedge clock);
    set_garbage();
    in_dmem_ack = 1'b0;
    chk("mid_req", out_dmem_req, 1);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_req",   out_dmem_req, 0);
    chk("arst_stall", out_stall, 0);
    chk("arst_cnt",   out_retire_cnt, 0);
    m_cnt = '0;  m_idx = '0;  m_data = '0;  m_instr = '0;
    @(negedge clock);
    set_bubble();
    in_dmem_ack = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("post_rst_pulse", {out_reg_wr_en, out_retire, out_bus_err, out_dmem_req}, 0);
    end
    chk_arch("post_rst");
    in_dmem_ack = 1'b0;

    // Retire counter wrap.
    in_act_write_res_to_reg = 1'b1;
    in_res = 16'h0F0F;  in_res_reg_idx = 4'd1;  in_instr = 16'hC001;
    repeat (65535) @(posedge clock);
    @(negedge clock);
    chk("cnt_max", out_retire_cnt, 16'hFFFF);
    @(posedge clock);
    @(negedge clock);
    chk("cnt_wrap", out_retire_cnt, 16'h0000);
    chk("wrap_wren", out_reg_wr_en, 1);
    in_act_write_res_to_reg = 1'b0;
    @(negedge clock);
    chk("wrap_idle", out_reg_wr_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
